uart_stream_bridge: RTL and testbench
=====================================

# uart_stream_bridge

Bridges the byte-stream pipeline of the USB serial core to a physical 8N1 asynchronous serial line. Bytes arriving from the USB host on the core's output stream are serialized onto `uart_tx`. Frames received on `uart_rx` are deserialized and presented to the core's input stream. The block sits between `usb_uart_core` and the board UART pins, so the chip works as a USB-to-serial adapter.

## Interface
- `CLKS_PER_BIT`, default 417: clk cycles per bit (417 gives 115200 baud at 48 MHz). Legal range is 8 or more.
- `clk`  in  1: 48 MHz system clock.
- `rst_n`  in  1: synchronous, active-low reset. Clock is `clk`.
- `s_data`  in  8: byte to transmit (from core `uart_out_data`).
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: bridge accepts `s_data` this cycle.
- `uart_tx`  out  1: serial output. Idle level is high.
- `uart_rx`  in  1: serial input. Asynchronous to `clk`.
- `m_data`  out  8: received byte (to core `uart_in_data`).
- `m_valid`  out  1: `m_data` is valid.
- `m_ready`  in  1: downstream accepts `m_data`.
- `rx_frame_err`  out  1: one-cycle pulse when a stop bit is sampled low.
- `rx_overrun`  out  1: one-cycle pulse when a byte is dropped because the holding register is full.

## Operation
- **Reset values:** `uart_tx`=1, `s_ready`=0, `m_valid`=0, `m_data`=0, both error pulses 0, TX and RX FSMs in IDLE, all counters 0.
- **TX FSM:** IDLE → START → DATA → STOP → IDLE.
  - `s_ready`=1 only in IDLE, and only from the first cycle after reset release.
  - A transfer occurs when `s_valid && s_ready`; `s_data` is latched into the shift register.
  - START drives 0. DATA drives bits LSB first, 8 bits. STOP drives 1.
  - Each state or bit lasts exactly `CLKS_PER_BIT` cycles.
  - `s_data` is not sampled outside the handshake.
- **RX input:** 2-FF synchronizer on `uart_rx`. All RX logic uses the synchronized value.
- **RX FSM:** IDLE → START → DATA → STOP → IDLE, with an extra WAIT_HIGH state.
  - IDLE: a synchronized low enters START and loads the counter with `CLKS_PER_BIT/2` (integer division).
  - START: when the counter expires, the line is re-sampled. If high, the start was a glitch: return to IDLE with no output. If low, go to DATA.
  - DATA: 8 samples spaced `CLKS_PER_BIT` apart, shifted in LSB first.
  - STOP: one sample `CLKS_PER_BIT` after the last data sample.
    - Stop = 1: deliver the byte and go to IDLE.
    - Stop = 0: pulse `rx_frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronized line is high, then go to IDLE. Break conditions therefore yield a single error.
- **Output holding register (one entry):**
  - Delivery sets `m_valid` and loads `m_data`.
  - `m_valid` and `m_data` hold stable until `m_valid && m_ready`, then `m_valid` clears.
  - Delivery while `m_valid=1` and `m_ready=0`: pulse `rx_overrun`, drop the new byte, keep the old one.
  - Delivery in the same cycle as `m_valid && m_ready`: load the new byte, keep `m_valid`=1, no overrun.
- TX and RX are fully independent. Simultaneous activity has no interaction.
- Reset asserted mid-frame aborts immediately to reset values. A partial TX frame is truncated with `uart_tx` forced high.

## Timing
- **TX latency:** handshake at edge N → `uart_tx` falls after edge N+1.
  - The frame occupies 10×`CLKS_PER_BIT` cycles.
  - `s_ready` returns high the cycle after STOP ends.
  - Minimum spacing between start bits is 10×`CLKS_PER_BIT`+1 cycles.
- **RX sample points:** let D be the cycle the synchronized line is first seen low in IDLE, i.e. pin fall plus 2 cycles.
  - Start check at D+`CLKS_PER_BIT/2`.
  - Data bit k (0..7) at D+`CLKS_PER_BIT/2`+(k+1)×`CLKS_PER_BIT`.
  - Stop at D+`CLKS_PER_BIT/2`+9×`CLKS_PER_BIT`.
  - `m_valid`, `rx_frame_err` or `rx_overrun` is registered one cycle after the stop sample.
- After a good stop sample, RX is in IDLE one cycle later and can detect a start bit immediately. It tolerates a stop bit as short as half a bit.
- Bit counter width is $clog2(`CLKS_PER_BIT`). Counters count down and reload on expiry. No wrap-around beyond the reload.

## Structure
- **Package `uart_bridge_pkg`:**
  - TX state enum (IDLE, START, DATA, STOP).
  - RX state enum (IDLE, START, DATA, STOP, WAIT_HIGH).
  - Frame constants: 8 data bits, 1 stop bit.
  - Default `CLKS_PER_BIT`.
- **Sub-module `uart_rx_deser`:** synchronizer, RX FSM, and the holding register with valid/ready and error pulses.
- The TX FSM lives inline in `uart_stream_bridge`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- **TX single byte:** send 0xA5 with `s_valid` held → `uart_tx` = 0,1,0,1,0,0,1,0,1,1, each level for 16 cycles. `s_ready` low for 160 cycles, high on cycle 161.
- **RX loopback:** connect `uart_tx` to `uart_rx` and send bytes 0x00, 0xFF, 0x3C with `m_ready`=1 → `m_data` matches each byte in order. `m_valid` pulses one cycle per byte. No error pulses.
- **RX backpressure and overrun:** hold `m_ready`=0 and inject 0x11 then 0x22 → `m_data` stays 0x11 and `rx_overrun` pulses once. Raise `m_ready` at the exact cycle of the 0x33 delivery → `m_data`=0x33, `m_valid` stays high, no overrun.
- **Framing error and break:** inject 0x55 with stop bit 0, then hold the line low for 40 bit times → exactly one `rx_frame_err` pulse and no `m_valid`. After the line returns high, a following 0x81 frame is received correctly.
- **Glitch and reset:** a 4-cycle low pulse on `uart_rx` → no output. Assert `rst_n`=0 mid TX frame → `uart_tx`=1 and `s_ready`=0 next cycle. `s_ready` returns to 1 one cycle after release.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared types and frame constants for the USB-core <-> 8N1 UART bridge.
package uart_bridge_pkg;

  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;
  localparam int DEFAULT_CLKS_PER_BIT = 417;  // 115200 baud at 48 MHz

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_stream_bridge_if.sv
// Byte stream with valid/ready handshake between the USB serial core and the bridge.
interface uart_stream_bridge_if;
  import uart_bridge_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_rx_deser.sv
// UART receiver: input synchronizer, 8N1 deserializer FSM and a one-entry
// output holding register with frame-error and overrun pulses.
module uart_rx_deser
  import uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         uart_rx,
  uart_stream_bridge_if.master         m,
  output logic                         rx_frame_err,
  output logic                         rx_overrun
);

  localparam int                CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int                BIT_W        = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  BIT_RELOAD   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_BIT     = CNT_W'(CLKS_PER_BIT / 2);
  // The detection cycle itself is the first half-bit cycle, so the start
  // check fires at count 1 and lands exactly CLKS_PER_BIT/2 after detection.
  localparam logic [CNT_W-1:0]  START_EXPIRE = CNT_W'(1);
  localparam logic [BIT_W-1:0]  LAST_BIT     = BIT_W'(DATA_BITS - 1);

  logic                 meta_q, sync_q;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 deliver, frame_err;
  logic [DATA_BITS-1:0] m_data_q;
  logic                 m_valid_q, ferr_q, ovr_q;

  assign m.data       = m_data_q;
  assign m.valid      = m_valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Synchronizer resets to the idle (high) line level so reset release
      // never looks like a start bit.
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      meta_q  <= uart_rx;
      sync_q  <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= frame_err;
      ovr_q   <= 1'b0;
      if (deliver) begin
        if (m_valid_q && !m.ready) begin
          ovr_q <= 1'b1;
        end else begin
          m_data_q  <= shift_q;
          m_valid_q <= 1'b1;
        end
      end else if (m_valid_q && m.ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!sync_q) begin
          cnt_d   = HALF_BIT;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == START_EXPIRE) begin
          if (sync_q) begin
            state_d = RX_IDLE;  // glitch shorter than half a bit
          end else begin
            cnt_d   = BIT_RELOAD;
            bit_d   = '0;
            state_d = RX_DATA;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = BIT_RELOAD;
          if (bit_q == LAST_BIT) state_d = RX_STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          if (sync_q) begin
            deliver = 1'b1;
            state_d = RX_IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (sync_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_stream_bridge.sv
// USB-to-serial bridge: serializes the core's output stream onto uart_tx
// (8N1) and hands bytes deserialized from uart_rx back to the core.
module uart_stream_bridge
  import uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_stream_bridge_if.slave  s,
  output logic                 uart_tx,
  input  logic                 uart_rx,
  uart_stream_bridge_if.master m,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
  localparam int               BIT_W      = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 run_q;  // low during reset and its release cycle
  logic                 accept;

  assign s.ready = run_q && (state_q == TX_IDLE);
  assign accept  = s.valid && s.ready;
  assign uart_tx = tx_q;

  // NOTE: state uses non-blocking assignments so every register samples
  // the pre-edge value of every other register, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      run_q   <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first; a path that
  // skipped one would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    unique case (state_q)
      TX_IDLE: begin
        if (accept) begin
          shift_d = s.data;
          cnt_d   = BIT_RELOAD;
          state_d = TX_START;
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (cnt_q == '0) begin
          cnt_d   = BIT_RELOAD;
          bit_d   = '0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TX_DATA: begin
        tx_d = shift_q[0];
        if (cnt_q == '0) begin
          cnt_d   = BIT_RELOAD;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) state_d = TX_STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt_q == '0) state_d = TX_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  uart_rx_deser #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rx      (uart_rx),
    .m            (m),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed bench for uart_stream_bridge at CLKS_PER_BIT=16: TX waveform,
// loopback, backpressure/overrun, framing error/break, glitch and reset.
module tb_uart_stream_bridge;
  import uart_bridge_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_tx, uart_rx, rx_frame_err, rx_overrun;
  logic loopback = 1'b0;
  logic rx_drv = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  uart_stream_bridge_if s_if ();
  uart_stream_bridge_if m_if ();

  assign uart_rx = loopback ? uart_tx : rx_drv;

  uart_stream_bridge #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s            (s_if),
    .uart_tx      (uart_tx),
    .uart_rx      (uart_rx),
    .m            (m_if),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  // Event monitor samples pre-edge values, i.e. what the DUT acts on.
  logic [7:0] rx_q [$];
  int n_valid_cyc = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (m_if.valid && m_if.ready) rx_q.push_back(m_if.data);
      if (m_if.valid) n_valid_cyc++;
      if (rx_frame_err) n_ferr++;
      if (rx_overrun) n_ovr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge right after the handshake.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    while (!s_if.ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("tx_ready_wait", 32'(s_if.ready), 32'd1);
    s_if.data  = b;
    s_if.valid = 1'b1;
    @(negedge clk);
    s_if.valid = 1'b0;
    s_if.data  = '0;
  endtask

  // Drives one 8N1 frame on rx_drv; the line is left at the stop level.
  task automatic inject(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      tick(CPB);
    end
  endtask

  logic [9:0] frame;
  logic       exp_tx;
  int         bit_bad [10];
  int         low_cnt;
  int         base_q, base_v, base_f, base_o;
  logic [7:0] loop_bytes [3] = '{8'h00, 8'hFF, 8'h3C};

  initial begin
    s_if.data  = '0;
    s_if.valid = 1'b0;
    m_if.ready = 1'b0;
    tick(4);

    // Reset state
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_s_ready", 32'(s_if.ready), 32'd0);
    check("rst_m_valid", 32'(m_if.valid), 32'd0);
    check("rst_m_data", 32'(m_if.data), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err), 32'd0);
    check("rst_overrun", 32'(rx_overrun), 32'd0);
    rst_n = 1'b1;
    check("ready_before_first_edge", 32'(s_if.ready), 32'd0);
    tick(1);
    check("ready_after_release", 32'(s_if.ready), 32'd1);

    // TX single byte 0xA5: j counts negedges after the handshake edge
    frame = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) bit_bad[b] = 0;
    low_cnt = 0;
    s_if.data  = 8'hA5;
    s_if.valid = 1'b1;
    @(negedge clk);
    s_if.valid = 1'b0;
    check("tx_high_after_accept", 32'(uart_tx), 32'd1);
    for (int j = 0; j <= 160; j++) begin
      if (j > 0) begin
        exp_tx = frame[(j - 1) / CPB];
        if (uart_tx !== exp_tx) bit_bad[(j - 1) / CPB]++;
      end
      if (!s_if.ready) low_cnt++;
      if (j < 160) @(negedge clk);
    end
    for (int b = 0; b < 10; b++) check($sformatf("tx_bit%0d_bad_cycles", b), 32'(bit_bad[b]), 32'd0);
    check("tx_ready_low_cycles", 32'(low_cnt), 32'd160);
    check("tx_ready_cycle_161", 32'(s_if.ready), 32'd1);

    // RX loopback
    tick(4);
    loopback   = 1'b1;
    m_if.ready = 1'b1;
    base_q = rx_q.size(); base_v = n_valid_cyc; base_f = n_ferr; base_o = n_ovr;
    for (int i = 0; i < 3; i++) send_byte(loop_bytes[i]);
    tick(12 * CPB);
    check("loop_byte_count", 32'(rx_q.size() - base_q), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("loop_byte%0d", i),
            (base_q + i < rx_q.size()) ? 32'(rx_q[base_q + i]) : 32'hDEAD, 32'(loop_bytes[i]));
    check("loop_valid_cycles", 32'(n_valid_cyc - base_v), 32'd3);
    check("loop_frame_err", 32'(n_ferr - base_f), 32'd0);
    check("loop_overrun", 32'(n_ovr - base_o), 32'd0);
    loopback = 1'b0;

    // Backpressure and overrun
    m_if.ready = 1'b0;
    tick(4);
    base_q = rx_q.size(); base_o = n_ovr;
    inject(8'h11, 1'b1);
    tick(4);
    inject(8'h22, 1'b1);
    tick(4);
    check("bp_valid_held", 32'(m_if.valid), 32'd1);
    check("bp_data_kept", 32'(m_if.data), 32'h11);
    check("bp_overrun_once", 32'(n_ovr - base_o), 32'd1);
    // Stop sample of a frame injected at negedge 0 lands on edge 155.
    fork
      inject(8'h33, 1'b1);
      begin
        tick(154);
        check("bp_data_before_33", 32'(m_if.data), 32'h11);
        m_if.ready = 1'b1;
        tick(1);
        check("bp_data_33", 32'(m_if.data), 32'h33);
        check("bp_valid_kept_33", 32'(m_if.valid), 32'd1);
      end
    join
    check("bp_no_new_overrun", 32'(n_ovr - base_o), 32'd1);
    check("bp_valid_cleared", 32'(m_if.valid), 32'd0);
    check("bp_consumed_count", 32'(rx_q.size() - base_q), 32'd2);
    check("bp_consumed_last",
          (rx_q.size() > 0) ? 32'(rx_q[rx_q.size() - 1]) : 32'hDEAD, 32'h33);

    // Framing error followed by a 40-bit break
    tick(4);
    base_q = rx_q.size(); base_v = n_valid_cyc; base_f = n_ferr;
    inject(8'h55, 1'b0);
    tick(40 * CPB);
    rx_drv = 1'b1;
    tick(3 * CPB);
    check("ferr_single_pulse", 32'(n_ferr - base_f), 32'd1);
    check("ferr_no_valid", 32'(n_valid_cyc - base_v), 32'd0);
    inject(8'h81, 1'b1);
    tick(2 * CPB);
    check("after_break_count", 32'(rx_q.size() - base_q), 32'd1);
    check("after_break_byte",
          (rx_q.size() > base_q) ? 32'(rx_q[base_q]) : 32'hDEAD, 32'h81);
    check("after_break_ferr", 32'(n_ferr - base_f), 32'd1);

    // Glitch on the RX line
    base_q = rx_q.size(); base_v = n_valid_cyc; base_f = n_ferr;
    rx_drv = 1'b0;
    tick(4);
    rx_drv = 1'b1;
    tick(3 * CPB);
    check("glitch_no_valid", 32'(n_valid_cyc - base_v), 32'd0);
    check("glitch_no_ferr", 32'(n_ferr - base_f), 32'd0);

    // Reset mid TX frame (0x00 keeps the line low through the data bits)
    send_byte(8'h00);
    tick(40);
    check("tx_low_before_reset", 32'(uart_tx), 32'd0);
    rst_n = 1'b0;
    tick(1);
    check("reset_tx_high", 32'(uart_tx), 32'd1);
    check("reset_ready_low", 32'(s_if.ready), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("release_ready_high", 32'(s_if.ready), 32'd1);
    check("release_tx_high", 32'(uart_tx), 32'd1);
    check("release_m_valid", 32'(m_if.valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
